// File: rtl/row_pixel_tx_if.sv
// Handshake bundle between a pixel producer, row_pixel_tx and the row consumer.
// The slave side is the row_pixel_tx block itself.
interface row_pixel_tx_if #(
   parameter int COL   = 1920,
   parameter int ROW   = 1080,
   parameter int WIDTH = 8
);
   localparam int PW = 4 * WIDTH;
   localparam int IW = (ROW > 1) ? $clog2(ROW) : 1;

   logic [PW-1:0]     pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [COL*PW-1:0] row_out;
   logic              row_valid;
   logic              row_ready;
   logic [IW-1:0]     row_idx;
   logic              row_last;
   logic              frame_done;

   modport master (
      output pix_in, pix_valid, row_ready,
      input  pix_ready, row_out, row_valid, row_idx, row_last, frame_done
   );

   modport slave (
      input  pix_in, pix_valid, row_ready,
      output pix_ready, row_out, row_valid, row_idx, row_last, frame_done
   );
endinterface

// File: rtl/row_pixel_tx.sv
// Packs an RGBA pixel stream into full rows for the median filter's row input.
// An assembly buffer fills while the output buffer waits for the consumer.
module row_pixel_tx #(
   parameter int COL   = 1920,
   parameter int ROW   = 1080,
   parameter int WIDTH = 8
) (
   input logic           CLK,
   input logic           RST,
   row_pixel_tx_if.slave bus
);
   localparam int PW = 4 * WIDTH;
   localparam int RW = COL * PW;
   localparam int CW = (COL > 1) ? $clog2(COL) : 1;
   localparam int IW = (ROW > 1) ? $clog2(ROW) : 1;
   localparam int BW = (RW > 1) ? $clog2(RW) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
   localparam logic [IW-1:0] ROW_LAST = IW'(ROW - 1);

   typedef enum logic {
      FILL,
      FULL
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0] col;
   logic [RW-1:0] asm_buf;
   logic [RW-1:0] row_direct;
   logic [RW-1:0] row_out_q;
   logic [IW-1:0] row_idx_q;
   logic [BW-1:0] slot_base;
   logic          row_valid_q;
   logic          frame_done_q;
   logic          has_row;
   logic          pix_ready_c;
   logic          accept;
   logic          last_col;
   logic          slot_free;
   logic          load;
   logic          load_asm;

   assign last_col  = (col == COL_LAST);
   assign slot_free = !row_valid_q || bus.row_ready;
   assign accept    = bus.pix_valid && pix_ready_c;

   // Pixel k of a row lands in slot COL-1-k, so column 0 ends up in the MSBs.
   assign slot_base = BW'(COL_LAST - col) * BW'(PW);

   // The last pixel bypasses the assembly buffer when the output slot is free,
   // giving a one-cycle latency from the final accept to row_valid.
   always_comb begin
      row_direct          = asm_buf;
      row_direct[PW-1:0]  = bus.pix_in;
   end

   // State register: FULL means a completed row is parked in the assembly buffer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_next  = state;
      pix_ready_c = 1'b0;
      load        = 1'b0;
      load_asm    = 1'b0;
      case (state)
         FILL: begin
            pix_ready_c = 1'b1;
            if (bus.pix_valid && last_col) begin
               if (slot_free) begin
                  load = 1'b1;
               end else begin
                  state_next = FULL;
               end
            end
         end
         FULL: begin
            if (slot_free) begin
               load       = 1'b1;
               load_asm   = 1'b1;
               state_next = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // A reset simply restarts the column count; stale assembly slots are
   // overwritten before they can ever be loaded into the output.
   always_ff @(posedge CLK) begin
      if (accept) begin
         asm_buf[slot_base +: PW] <= bus.pix_in;
      end
   end

   // Output buffer, row numbering and frame tracking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         col          <= '0;
         row_out_q    <= '0;
         row_valid_q  <= 1'b0;
         row_idx_q    <= '0;
         has_row      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= row_valid_q && bus.row_ready && (row_idx_q == ROW_LAST);
         if (accept) begin
            col <= last_col ? '0 : col + 1'b1;
         end
         if (load) begin
            row_out_q   <= load_asm ? asm_buf : row_direct;
            row_valid_q <= 1'b1;
            has_row     <= 1'b1;
            if (has_row) begin
               row_idx_q <= (row_idx_q == ROW_LAST) ? '0 : row_idx_q + 1'b1;
            end
         end else if (row_valid_q && bus.row_ready) begin
            row_valid_q <= 1'b0;
         end
      end
   end

   assign bus.pix_ready  = pix_ready_c;
   assign bus.row_out    = row_out_q;
   assign bus.row_valid  = row_valid_q;
   assign bus.row_idx    = row_idx_q;
   assign bus.row_last   = row_valid_q && (row_idx_q == ROW_LAST);
   assign bus.frame_done = frame_done_q;
endmodule
